mux_scan_nbit: RTL and testbench
================================

# mux_scan_nbit

Parametrised, registered N-bit multiplexer with CH input channels and two modes. In manual mode an external select picks the channel. In scan mode an internal dwell counter steps through the channels round-robin. It sits between the per-digit hex seven-segment decoders and the shared segment/digit-enable pins, and drives the selected value, the channel index, a one-hot digit enable and a change strobe.

## Interface
- N, default 8: data width per channel.
- CH, default 4: channel count, 2..16.
- SEL_W, default 2: select/index width. Must satisfy 2^SEL_W >= CH.
- DWELL, default 1000: number of enabled cycles spent on each channel in scan mode, >= 1.

- clk  in  1  single clock. All state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  N*CH  flattened channel data. Channel k occupies din[k*N +: N].
- mode  in  1  0 = manual select, 1 = automatic scan.
- sel  in  SEL_W  manual channel select. Ignored in scan mode.
- en  in  1  dwell-counter enable (tick). Scan mode only.
- y  out  N  registered data of the active channel.
- ch  out  SEL_W  registered active channel index.
- onehot  out  CH  registered one-hot digit enable; bit ch is high.
- strobe  out  1  one-cycle pulse when ch changes value.

## Operation
- State: ch register, dwell counter cnt (0..DWELL-1), y, onehot and strobe registers.
- Every cycle: y <= din slice of next_ch, so y and ch always update together.
- Every cycle: onehot <= 1 << next_ch, subject to the blanking rule under Configuration.
- Manual mode (mode=0):
  - If sel < CH, next_ch = sel. If sel >= CH (possible when CH is not a power of two), ch holds its value.
  - cnt is held at 0.
- Scan mode (mode=1):
  - en=0: cnt and ch hold.
  - en=1 and cnt < DWELL-1: cnt increments.
  - en=1 and cnt = DWELL-1: cnt goes to 0 and ch advances. CH-1 wraps to 0.
- Mode switches:
  - Manual to scan: scanning starts from the current ch with cnt=0.
  - Scan to manual: ch takes sel (if in range) on the first manual cycle.
- strobe <= (next_ch != ch). A sel held constant gives no pulses.
- y tracks din changes with one cycle of latency, even when ch is constant.

## Timing
- Reset (async assert, release synchronised by the user): y=0, ch=0, cnt=0, onehot=0 (all digits blank), strobe=0.
- After reset release:
  - First rising edge: onehot=1<<ch and y=din[ch] are loaded.
  - strobe stays 0 on that edge because ch is unchanged.
- Manual latency: sel to y/ch/onehot/strobe is 1 cycle.
- Scan rate: with en held high, ch changes every DWELL cycles. In general, ch changes every DWELL cycles in which en=1.
- Reset mid-scan: all outputs clear immediately. Scanning restarts at channel 0 with a full dwell.
- Mode change and terminal count in the same cycle: mode wins. Manual select applies and no advance occurs.

## Configuration
- MUX_SCAN_BLANK_EN defined:
  - On every ch change, onehot is forced to all-zero for that one cycle, while y already carries the new data.
  - The new one-hot bit asserts on the following cycle. This gives ghost-free digit switching.
  - strobe is unaffected.
- MUX_SCAN_BLANK_EN undefined: onehot changes in the same cycle as ch and y.

## Test plan
Common setup: N=8, CH=4, DWELL=3; din ch0=200, ch1=122, ch2=255, ch3=17.
- Reset check: hold rst_n=0 mid-cycle → y=0, ch=0, onehot=0000, strobe=0 asynchronously. Release → next edge y=200, onehot=0001, strobe=0.
- Manual: mode=0, sel=0,1,2,3, each held 2 cycles → one cycle after each sel change y=200,122,255,17, onehot=0001,0010,0100,1000, strobe one-cycle pulse per change only.
- Scan: mode=1, en=1 → ch sequence 0,1,2,3,0 changing every 3 cycles (wrap checked), strobe single-cycle at each change.
- Scan with gated en: en toggling 1/0 → each channel held 6 cycles. en=0 throughout → ch frozen.
- Reset mid-scan at ch=2, cnt=1 → outputs clear at once. After release y=200, then ch=1 after 3 enabled cycles.
- Blanking and out-of-range select: with MUX_SCAN_BLANK_EN defined, onehot=0000 for exactly one cycle at each scan change with y already new. With CH=3, SEL_W=2, sel=3 in manual mode → ch, y and onehot hold, strobe=0.

Source files
------------

// File: rtl/mux_scan_nbit.sv
// mux_scan_nbit: registered N-bit, CH-channel multiplexer with manual select
// and round-robin scan modes. It drives shared seven-segment pins from
// per-digit decoders.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   din     flattened channel data, channel k at din[k*N +: N]
//   mode    0 = manual select, 1 = automatic scan
//   sel     manual channel select (ignored in scan mode)
//   en      dwell tick, used in scan mode only
//   y       registered data of the active channel
//   ch      registered active channel index
//   onehot  registered one-hot digit enable (all-zero while in reset)
//   strobe  one-cycle pulse when ch changes
//
// Optional feature:
//   MUX_SCAN_BLANK_EN  blanks onehot for one cycle on every channel change.
//                      y and ch still switch on the same edge, so the wrong
//                      digit is never lit (ghost-free switching).

module mux_scan_nbit #(
  parameter int unsigned N     = 8,
  parameter int unsigned CH    = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*CH-1:0]   din,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              en,
  output logic [N-1:0]      y,
  output logic [SEL_W-1:0]  ch,
  output logic [CH-1:0]     onehot,
  output logic              strobe
);

  localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CH - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt_c;
  logic [SEL_W-1:0] next_ch_c;
  logic             ch_chg_c;
  logic [N-1:0]     y_next_c;
  logic [CH-1:0]    onehot_next_c;

  // Next channel and dwell count. A manual-mode cycle always takes precedence
  // over a terminal count, so a mode switch never causes an extra advance.
  always_comb begin
    next_ch_c  = ch;
    next_cnt_c = cnt;
    if (!mode) begin
      next_cnt_c = '0;
      // An out-of-range select (CH not a power of two) leaves ch unchanged.
      if (32'(sel) < CH) begin
        next_ch_c = sel;
      end
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        next_cnt_c = '0;
        next_ch_c  = (ch == CH_LAST) ? '0 : ch + SEL_W'(1);
      end else begin
        next_cnt_c = cnt + CNT_W'(1);
      end
    end
  end

  assign ch_chg_c = (next_ch_c != ch);

  // Data slice and digit enable for the channel being loaded.
  always_comb begin
    y_next_c      = '0;
    onehot_next_c = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (next_ch_c == SEL_W'(k)) begin
        y_next_c         = din[k*N +: N];
        onehot_next_c[k] = 1'b1;
      end
    end
`ifdef MUX_SCAN_BLANK_EN
    // The new digit lights on the cycle after the switch.
    if (ch_chg_c) begin
      onehot_next_c = '0;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch     <= '0;
      cnt    <= '0;
      y      <= '0;
      onehot <= '0;
      strobe <= 1'b0;
    end else begin
      ch     <= next_ch_c;
      cnt    <= next_cnt_c;
      y      <= y_next_c;
      onehot <= onehot_next_c;
      strobe <= ch_chg_c;
    end
  end

endmodule

// File: tb/tb_mux_scan_nbit.sv
// Self-checking bench for mux_scan_nbit: a 4-channel instance checked against
// a cycle-level behavioural model, plus a 3-channel instance used for the
// out-of-range select case.

module tb_mux_scan_nbit;

  localparam int unsigned N     = 8;
  localparam int unsigned CH    = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned DWELL = 3;

`ifdef MUX_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N*CH-1:0]   din = '0;
  logic              mode = 1'b0;
  logic [SEL_W-1:0]  sel = '0;
  logic              en = 1'b0;
  logic [N-1:0]      y;
  logic [SEL_W-1:0]  ch;
  logic [CH-1:0]     onehot;
  logic              strobe;

  logic [3*N-1:0]    din3 = {8'd33, 8'd66, 8'd99};
  logic              mode3 = 1'b0;
  logic [1:0]        sel3 = 2'd0;
  logic              en3 = 1'b0;
  logic [N-1:0]      y3;
  logic [1:0]        ch3;
  logic [2:0]        oh3;
  logic              st3;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int          m_ch  = 0;
  int          m_cnt = 0;
  logic [7:0]  m_y   = '0;
  logic [3:0]  m_oh  = '0;
  logic        m_st  = 1'b0;

  wire [14:0] obs  = {y, ch, onehot, strobe};
  wire [14:0] expv = {m_y, 2'(m_ch), m_oh, m_st};

  mux_scan_nbit #(.N(N), .CH(CH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel), .en(en),
    .y(y), .ch(ch), .onehot(onehot), .strobe(strobe)
  );

  mux_scan_nbit #(.N(N), .CH(3), .SEL_W(2), .DWELL(DWELL)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .mode(mode3), .sel(sel3), .en(en3),
    .y(y3), .ch(ch3), .onehot(oh3), .strobe(st3)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ch = 0; m_cnt = 0; m_y = '0; m_oh = '0; m_st = 1'b0;
  endtask

  // One rising edge of the spec's rules: manual selects, scan counts enabled
  // ticks and advances after DWELL of them.
  task automatic model_edge();
    int nch;
    nch = m_ch;
    if (mode == 1'b0) begin
      m_cnt = 0;
      if (int'(sel) < int'(CH)) nch = int'(sel);
    end else if (en) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == int'(DWELL)) begin
        m_cnt = 0;
        nch = (m_ch + 1) % int'(CH);
      end
    end
    m_st = (nch != m_ch);
    m_oh = (BLANK && m_st) ? 4'b0000 : 4'(1 << nch);
    m_y  = din[nch*N +: N];
    m_ch = nch;
  endtask

  // Drive inputs, clock once, update the model, sample 1 ns after the edge.
  task automatic step(input logic md, input logic [1:0] s, input logic e);
    mode = md; sel = s; en = e;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    din = {8'd17, 8'd255, 8'd122, 8'd200};
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== 15'h0) begin
      errors++; $display("FAIL reset_async: got %h want %h", obs, 15'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 2'd0, 1'b0);
    checks++;
    if ({y, onehot, strobe} !== {8'd200, 4'b0001, 1'b0}) begin
      errors++; $display("FAIL reset_release: got y=%0d oh=%b st=%b want y=200 oh=0001 st=0", y, onehot, strobe);
    end
  endtask

  task automatic test_manual();
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 2; r++) begin
        step(1'b0, 2'(s), 1'b0);
        checks++;
        if (obs !== expv) begin
          errors++; $display("FAIL manual sel=%0d r=%0d: got %h want %h", s, r, obs, expv);
        end
      end
    end
    // Random selects and changing data: y follows din one cycle later.
    for (int i = 0; i < 20; i++) begin
      din = N*CH'($urandom);
      step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom));
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL manual_rand i=%0d: got %h want %h", i, obs, expv);
      end
    end
    din = {8'd17, 8'd255, 8'd122, 8'd200};
  endtask

  task automatic test_scan();
    int nstb;
    nstb = 0;
    step(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 2'd3, 1'b1);
      nstb += int'(strobe);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL scan i=%0d: got %h want %h", i, obs, expv);
      end
    end
    checks++;
    if (nstb != 5 || ch !== 2'd1) begin
      errors++; $display("FAIL scan_count: got strobes=%0d ch=%0d want strobes=5 ch=1", nstb, ch);
    end
  endtask

  task automatic test_gated_en();
    logic [1:0] frozen;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 2'd0, 1'(i % 2 == 0));
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL gated i=%0d: got %h want %h", i, obs, expv);
      end
    end
    frozen = ch;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, 1'b0);
      checks++;
      if (ch !== frozen || strobe !== 1'b0 || obs !== expv) begin
        errors++; $display("FAIL en_low i=%0d: got ch=%0d st=%b want ch=%0d st=0", i, ch, strobe, frozen);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b1, 2'd0, 1'b1);
      found = (m_ch == 2 && m_cnt == 1);
    end
    checks++;
    if (!found || obs !== expv) begin
      errors++; $display("FAIL midscan_reach: got %h found=%0d want %h found=1", obs, found, expv);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== 15'h0) begin
      errors++; $display("FAIL midscan_async: got %h want %h", obs, 15'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 2'd0, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL midscan_restart i=%0d: got %h want %h", i, obs, expv);
      end
      if (i == 0) begin
        checks++;
        if (y !== 8'd200 || ch !== 2'd0) begin
          errors++; $display("FAIL midscan_first: got y=%0d ch=%0d want y=200 ch=0", y, ch);
        end
      end
      if (i == 2) begin
        checks++;
        if (ch !== 2'd1) begin
          errors++; $display("FAIL midscan_dwell: got ch=%0d want ch=1", ch);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) din = N*CH'($urandom);
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 3) != 0));
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random i=%0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_out_of_range();
    sel3 = 2'd1;
    @(posedge clk); #1;
    checks++;
    if ({ch3, y3, oh3, st3} !== {2'd1, 8'd66, (BLANK ? 3'b000 : 3'b010), 1'b1}) begin
      errors++; $display("FAIL oor_sel1: got ch=%0d y=%0d oh=%b st=%b want ch=1 y=66", ch3, y3, oh3, st3);
    end
    sel3 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ch3, y3, oh3, st3} !== {2'd1, 8'd66, 3'b010, 1'b0}) begin
        errors++; $display("FAIL oor_hold i=%0d: got ch=%0d y=%0d oh=%b st=%b want ch=1 y=66 oh=010 st=0", i, ch3, y3, oh3, st3);
      end
    end
    sel3 = 2'd2;
    @(posedge clk); #1;
    checks++;
    if ({ch3, y3, st3} !== {2'd2, 8'd33, 1'b1}) begin
      errors++; $display("FAIL oor_sel2: got ch=%0d y=%0d st=%b want ch=2 y=33 st=1", ch3, y3, st3);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_gated_en();
    test_reset_mid_scan();
    test_random();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
